ex_mem_stage_reg: RTL and testbench

- EX/MEM pipeline register directly downstream of the EX-stage ALU.
- Latches the ALU result, zero flag, store data, destination register and MEM/WB control bits.
- Resolves the branch decision one cycle after EX, and supplies the EX→EX forwarding tap back to the ALU operand mux.
- Supports stall (hold), flush (bubble insert) and a sticky illegal-control error flag.

---
 rtl/ex_mem_stage_reg.sv | 160 ++++++++++++++++
 tb/tb_ex_mem_stage_reg.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_reg
//   EX/MEM pipeline register that sits directly after the EX-stage ALU.
//   It latches the ALU result, zero flag, store data, branch target,
//   destination register and the MEM/WB control bits. It resolves the branch
//   decision from registered state and drives the EX->EX forwarding tap.
//   Supports stall (hold), flush (bubble) and a sticky illegal-control flag.
//
//   Optional build macro: EXMEM_PERF_CNT_EN
//     defined   : stallCnt / flushCnt are saturating 32-bit event counters
//     undefined : stallCnt / flushCnt are tied to zero, no counter flops
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   stall, flush               hold / bubble insert (flush wins)
//   validIn                    EX entry is a real instruction
//   outAlu, zeroAlu            ALU result and zero flag
//   storeData, branchTarget    store value and computed branch target
//   writeReg                   destination register index
//   regWrite..branchNe         control bits from ID/EX
//   validMem, aluMem, storeMem, targetMem, writeRegMem,
//   regWriteMem, memReadMem, memWriteMem, memToRegMem   latched MEM entry
//   pcSrcMem                   branch taken
//   fwdEn, fwdReg, fwdData     forwarding tap to the EX operand mux
//   errIllegal                 sticky: memRead & memWrite seen together
//   stallCnt, flushCnt         performance counters
// ---------------------------------------------------------------------------
module ex_mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              validIn,
  input  logic [DATA_W-1:0] outAlu,
  input  logic              zeroAlu,
  input  logic [DATA_W-1:0] storeData,
  input  logic [DATA_W-1:0] branchTarget,
  input  logic [REG_W-1:0]  writeReg,
  input  logic              regWrite,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              memToReg,
  input  logic              branchEq,
  input  logic              branchNe,
  output logic              validMem,
  output logic [DATA_W-1:0] aluMem,
  output logic [DATA_W-1:0] storeMem,
  output logic [DATA_W-1:0] targetMem,
  output logic [REG_W-1:0]  writeRegMem,
  output logic              regWriteMem,
  output logic              memReadMem,
  output logic              memWriteMem,
  output logic              memToRegMem,
  output logic              pcSrcMem,
  output logic              fwdEn,
  output logic [REG_W-1:0]  fwdReg,
  output logic [DATA_W-1:0] fwdData,
  output logic              errIllegal,
  output logic [31:0]       stallCnt,
  output logic [31:0]       flushCnt
);

  // Registered branch-resolution state not exported as ports.
  logic zero_p1;
  logic branchEq_p1;
  logic branchNe_p1;

  logic capture;
  logic illegal;

  assign capture = ~flush & ~stall;
  // A real instruction that both reads and writes memory is malformed.
  assign illegal = validIn & memRead & memWrite;

  // ---- EX -> MEM boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validMem    <= 1'b0;
      aluMem      <= '0;
      storeMem    <= '0;
      targetMem   <= '0;
      writeRegMem <= '0;
      regWriteMem <= 1'b0;
      memReadMem  <= 1'b0;
      memWriteMem <= 1'b0;
      memToRegMem <= 1'b0;
      zero_p1     <= 1'b0;
      branchEq_p1 <= 1'b0;
      branchNe_p1 <= 1'b0;
    end else if (flush) begin
      validMem    <= 1'b0;
      aluMem      <= '0;
      storeMem    <= '0;
      targetMem   <= '0;
      writeRegMem <= '0;
      regWriteMem <= 1'b0;
      memReadMem  <= 1'b0;
      memWriteMem <= 1'b0;
      memToRegMem <= 1'b0;
      zero_p1     <= 1'b0;
      branchEq_p1 <= 1'b0;
      branchNe_p1 <= 1'b0;
    end else if (!stall) begin
      validMem    <= validIn;
      aluMem      <= outAlu;
      storeMem    <= storeData;
      targetMem   <= branchTarget;
      writeRegMem <= writeReg;
      // Writes to register 0 are architecturally discarded.
      regWriteMem <= validIn & regWrite & (writeReg != '0);
      // Illegal read+write pair is neutralised; the entry stays valid.
      memReadMem  <= validIn & memRead & ~illegal;
      memWriteMem <= validIn & memWrite & ~illegal;
      memToRegMem <= validIn & memToReg;
      zero_p1     <= zeroAlu;
      branchEq_p1 <= validIn & branchEq;
      branchNe_p1 <= validIn & branchNe;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errIllegal <= 1'b0;
    end else if (capture && illegal) begin
      errIllegal <= 1'b1;
    end
  end

  assign pcSrcMem = validMem & ((branchEq_p1 & zero_p1) | (branchNe_p1 & ~zero_p1));
  // Load data is not available until after MEM, so loads cannot forward here.
  assign fwdEn    = validMem & regWriteMem & ~memToRegMem;
  assign fwdReg   = writeRegMem;
  assign fwdData  = aluMem;

`ifdef EXMEM_PERF_CNT_EN
  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (flush) begin
        flushCnt <= satInc(flushCnt);
      end else if (stall) begin
        stallCnt <= satInc(stallCnt);
      end
    end
  end
`else
  assign stallCnt = '0;
  assign flushCnt = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
module tb_ex_mem_stage_reg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall, flush, validIn;
  logic [DATA_W-1:0] outAlu, storeData, branchTarget;
  logic              zeroAlu;
  logic [REG_W-1:0]  writeReg;
  logic              regWrite, memRead, memWrite, memToReg, branchEq, branchNe;
  logic              validMem, regWriteMem, memReadMem, memWriteMem, memToRegMem;
  logic [DATA_W-1:0] aluMem, storeMem, targetMem, fwdData;
  logic [REG_W-1:0]  writeRegMem, fwdReg;
  logic              pcSrcMem, fwdEn, errIllegal;
  logic [31:0]       stallCnt, flushCnt;

  int compared   = 0;
  int mismatched = 0;

  ex_mem_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .validIn(validIn),
    .outAlu(outAlu), .zeroAlu(zeroAlu), .storeData(storeData),
    .branchTarget(branchTarget), .writeReg(writeReg),
    .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .branchEq(branchEq), .branchNe(branchNe),
    .validMem(validMem), .aluMem(aluMem), .storeMem(storeMem),
    .targetMem(targetMem), .writeRegMem(writeRegMem),
    .regWriteMem(regWriteMem), .memReadMem(memReadMem),
    .memWriteMem(memWriteMem), .memToRegMem(memToRegMem),
    .pcSrcMem(pcSrcMem), .fwdEn(fwdEn), .fwdReg(fwdReg), .fwdData(fwdData),
    .errIllegal(errIllegal), .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] alu, store, target;
    logic [4:0]  wr;
    logic        rw, mr, mw, m2r, zero, beq, bne, pcSrc, fwdEn, err;
    logic [31:0] sc, fc;
  } exp_t;

  exp_t m;
  exp_t q[$];

  function automatic exp_t zeroState();
    exp_t z;
    z = '{valid: 1'b0, alu: 32'h0, store: 32'h0, target: 32'h0, wr: 5'h0,
          rw: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0, zero: 1'b0, beq: 1'b0,
          bne: 1'b0, pcSrc: 1'b0, fwdEn: 1'b0, err: 1'b0, sc: 32'h0, fc: 32'h0};
    return z;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input exp_t e);
    logic [31:0] expSc, expFc;
`ifdef EXMEM_PERF_CNT_EN
    expSc = e.sc; expFc = e.fc;
`else
    expSc = 32'h0; expFc = 32'h0;
`endif
    chk({tag, ".validMem"},    validMem,    e.valid);
    chk({tag, ".aluMem"},      aluMem,      e.alu);
    chk({tag, ".storeMem"},    storeMem,    e.store);
    chk({tag, ".targetMem"},   targetMem,   e.target);
    chk({tag, ".writeRegMem"}, writeRegMem, e.wr);
    chk({tag, ".regWriteMem"}, regWriteMem, e.rw);
    chk({tag, ".memReadMem"},  memReadMem,  e.mr);
    chk({tag, ".memWriteMem"}, memWriteMem, e.mw);
    chk({tag, ".memToRegMem"}, memToRegMem, e.m2r);
    chk({tag, ".pcSrcMem"},    pcSrcMem,    e.pcSrc);
    chk({tag, ".fwdEn"},       fwdEn,       e.fwdEn);
    chk({tag, ".fwdReg"},      fwdReg,      e.wr);
    chk({tag, ".fwdData"},     fwdData,     e.alu);
    chk({tag, ".errIllegal"},  errIllegal,  e.err);
    chk({tag, ".stallCnt"},    stallCnt,    expSc);
    chk({tag, ".flushCnt"},    flushCnt,    expFc);
  endtask

  // Reference behaviour of one clock edge given the currently driven inputs.
  task automatic modelStep();
    logic ill;
    if (flush) begin
      m.valid = 0; m.alu = 0; m.store = 0; m.target = 0; m.wr = 0;
      m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0; m.zero = 0; m.beq = 0; m.bne = 0;
      if (m.fc != 32'hFFFF_FFFF) m.fc = m.fc + 1;
    end else if (stall) begin
      if (m.sc != 32'hFFFF_FFFF) m.sc = m.sc + 1;
    end else begin
      ill     = validIn && memRead && memWrite;
      m.valid = validIn;
      m.alu   = outAlu;
      m.store = storeData;
      m.target = branchTarget;
      m.wr    = writeReg;
      m.rw    = validIn && regWrite && (writeReg != 0);
      m.mr    = validIn && memRead && !ill;
      m.mw    = validIn && memWrite && !ill;
      m.m2r   = validIn && memToReg;
      m.zero  = zeroAlu;
      m.beq   = validIn && branchEq;
      m.bne   = validIn && branchNe;
      if (ill) m.err = 1;
    end
    m.pcSrc = m.valid && ((m.beq && m.zero) || (m.bne && !m.zero));
    m.fwdEn = m.valid && m.rw && !m.m2r;
  endtask

  task automatic cycle(input string tag);
    exp_t e;
    modelStep();
    q.push_back(m);
    @(posedge clk);
    #1;
    compared++;
    if (q.size() == 0) begin
      mismatched++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = q.pop_front();
      checkAll(tag, e);
    end
  endtask

  task automatic idle();
    stall = 0; flush = 0; validIn = 0; outAlu = 0; zeroAlu = 0; storeData = 0;
    branchTarget = 0; writeReg = 0; regWrite = 0; memRead = 0; memWrite = 0;
    memToReg = 0; branchEq = 0; branchNe = 0;
  endtask

  task automatic load(input logic [31:0] alu, input logic [4:0] wr, input logic rw,
                      input logic m2r);
    idle();
    validIn = 1; outAlu = alu; writeReg = wr; regWrite = rw; memToReg = m2r;
    storeData = alu ^ 32'hA5A5_A5A5; branchTarget = alu + 32'h100;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    m = zeroState();
    reset = 1;
    #12;
    checkAll("resetHeld", zeroState());
    @(negedge clk);
    reset = 0;

    // Reset asserted between edges clears everything at once.
    load(32'h1234_5678, 5'd9, 1, 0);
    cycle("preReset");
    chk("preReset.aluConst", aluMem, 32'h1234_5678);
    #2 reset = 1;
    #1;
    m = zeroState();
    checkAll("midReset", m);
    #3 reset = 0;

    // Capture and forward.
    load(32'hDEAD_BEEF, 5'd5, 1, 0);
    cycle("capFwd");
    chk("capFwd.aluConst", aluMem, 32'hDEAD_BEEF);
    chk("capFwd.fwdEnConst", fwdEn, 1'b1);
    chk("capFwd.fwdRegConst", fwdReg, 5'd5);
    load(32'hDEAD_BEEF, 5'd0, 1, 0);
    cycle("capR0");
    chk("capR0.rwConst", regWriteMem, 1'b0);
    chk("capR0.fwdEnConst", fwdEn, 1'b0);

    // Stall holds, then flush wins over stall.
    load(32'h10, 5'd3, 1, 0);
    zeroAlu = 1;
    cycle("capStall");
    for (int i = 0; i < 3; i++) begin
      load(32'h1000 + i, 5'd20 + i, 1, 0);
      zeroAlu = 0;
      stall = 1;
      cycle("stall");
      chk("stall.aluConst", aluMem, 32'h10);
    end
    stall = 1; flush = 1;
    cycle("stallFlush");
    chk("stallFlush.validConst", validMem, 1'b0);
`ifdef EXMEM_PERF_CNT_EN
    chk("perf.stallConst", stallCnt, 32'd3);
    chk("perf.flushConst", flushCnt, 32'd1);
`endif

    // Branch resolution.
    idle(); validIn = 1; branchEq = 1; zeroAlu = 1; branchTarget = 32'h40;
    cycle("beqTaken");
    chk("beqTaken.pcConst", pcSrcMem, 1'b1);
    chk("beqTaken.tgtConst", targetMem, 32'h40);
    zeroAlu = 0;
    cycle("beqNot");
    chk("beqNot.pcConst", pcSrcMem, 1'b0);
    idle(); validIn = 1; branchNe = 1; zeroAlu = 0;
    cycle("bneTaken");
    chk("bneTaken.pcConst", pcSrcMem, 1'b1);
    idle(); validIn = 0; branchEq = 1; zeroAlu = 1;
    cycle("beqBubble");
    chk("beqBubble.pcConst", pcSrcMem, 1'b0);
    idle(); validIn = 1; branchEq = 1; branchNe = 1; zeroAlu = 0;
    cycle("bothZ0");
    zeroAlu = 1;
    cycle("bothZ1");
    chk("bothZ1.pcConst", pcSrcMem, 1'b1);

    // Illegal control pair: sticky until reset, survives flush.
    idle(); validIn = 1; memRead = 1; memWrite = 1; outAlu = 32'h77;
    cycle("illegal");
    chk("illegal.errConst", errIllegal, 1'b1);
    chk("illegal.validConst", validMem, 1'b1);
    load(32'h55, 5'd4, 1, 0);
    cycle("afterIll1");
    flush = 1;
    cycle("afterIllFlush");
    load(32'h66, 5'd6, 1, 0);
    cycle("afterIll2");
    chk("afterIll2.errConst", errIllegal, 1'b1);

    // Load result is not forwardable.
    idle(); validIn = 1; memRead = 1; memToReg = 1; regWrite = 1; writeReg = 5'd7;
    cycle("loadNoFwd");
    chk("loadNoFwd.rwConst", regWriteMem, 1'b1);
    chk("loadNoFwd.fwdConst", fwdEn, 1'b0);

    // Mixed random traffic against the reference.
    for (int i = 0; i < 40; i++) begin
      validIn = 1'($urandom); outAlu = $urandom; storeData = $urandom;
      branchTarget = $urandom; zeroAlu = 1'($urandom); writeReg = 5'($urandom);
      regWrite = 1'($urandom); memRead = 1'($urandom); memWrite = 1'($urandom);
      memToReg = 1'($urandom); branchEq = 1'($urandom); branchNe = 1'($urandom);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end

    // Reset clears the sticky error.
    idle();
    @(negedge clk);
    reset = 1;
    #1;
    m = zeroState();
    checkAll("finalReset", m);
    @(negedge clk);
    reset = 0;

    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $error("FAIL drain observed=%0d expected=0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
